// File: rtl/source_recv_ctrl_pkg.sv
// Shared definitions for the source receive (fill) controller: FSM states,
// status codes exchanged with the send controller and the length check.
package source_recv_ctrl_pkg;

    localparam int ADDR_W    = 10;
    localparam int MAX_BYTES = 2048;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN,
        S_REQ,
        S_WAIT_DONE,
        S_ERR
    } state_t;

    // Values reported on err
    localparam logic [3:0] ERR_IDLE = 4'd0;
    localparam logic [3:0] ERR_FILL = 4'd1;
    localparam logic [3:0] ERR_SEND = 4'd2;
    localparam logic [3:0] ERR_LEN  = 4'd3;

    // Values reported by the send controller on send_status
    localparam logic [3:0] SS_IDLE    = 4'd0;
    localparam logic [3:0] SS_WAITING = 4'd1;
    localparam logic [3:0] SS_SENDING = 4'd2;

    // A packet must be a non-zero, even number of bytes that fits the RAM.
    function automatic logic len_bad(input logic [31:0] len, input logic [31:0] max_bytes);
        return (len == 32'd0) || len[0] || (len > max_bytes);
    endfunction

endpackage

// File: rtl/source_recv_ctrl.sv
// Fill stage of the source send path: copies a packet from the receive FIFO
// into the shared packet RAM, then hands it to the send controller and waits
// for the sender to go idle again.
module source_recv_ctrl
    import source_recv_ctrl_pkg::*;
#(
    parameter int ADDR_W    = source_recv_ctrl_pkg::ADDR_W,
    parameter int MAX_BYTES = source_recv_ctrl_pkg::MAX_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       pkt_length,
    input  logic              fifo_empty,
    output logic              fifo_rden,
    input  logic [15:0]       fifo_q,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [15:0]       ram_wdata,
    output logic              begin_send,
    output logic [31:0]       data_length,
    input  logic [3:0]        send_status,
    output logic              done,
    output logic [3:0]        err
);

    // Word counters are one bit wider than the address so a full RAM
    // (2^ADDR_W words) can be represented.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic [31:0]        data_length_q, data_length_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [3:0]         err_q, err_d;
    logic               begin_send_q, begin_send_d;
    logic               done_q, done_d;
    logic               rd_req;

    // Write-path pipeline registers
    logic               rd_vld_q;
    logic               ram_wren_q;
    logic [ADDR_W-1:0]  ram_waddr_q;
    logic [15:0]        ram_wdata_q;

    // FIFO is non-show-ahead: a read here returns data one cycle later.
    assign rd_req = (state_q == S_FILL) && !fifo_empty && (rd_cnt_q < words_q);

    // Next-state, counter and handshake logic
    always_comb begin
        state_d       = state_q;
        data_length_d = data_length_q;
        words_d       = words_q;
        rd_cnt_d      = rd_cnt_q;
        wr_cnt_d      = wr_cnt_q;
        err_d         = err_q;
        begin_send_d  = begin_send_q;
        done_d        = 1'b0;

        if (rd_req) begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
        end
        if (rd_vld_q) begin
            wr_cnt_d = wr_cnt_q + CNT_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_length_d = pkt_length;
                    words_d       = pkt_length[CNT_W:1];
                    rd_cnt_d      = '0;
                    wr_cnt_d      = '0;
                    if (len_bad(pkt_length, 32'(MAX_BYTES))) begin
                        state_d = S_ERR;
                        err_d   = ERR_LEN;
                    end else begin
                        state_d = S_FILL;
                        err_d   = ERR_FILL;
                    end
                end
            end
            S_FILL: begin
                // Leave as soon as the last read is issued; the final write
                // is still in flight and is awaited in DRAIN.
                if (rd_req && ((rd_cnt_q + CNT_ONE) == words_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Nothing left in the write pipe: ram_wren is low from the
                // same edge that raises begin_send.
                if ((wr_cnt_q == words_q) && !rd_vld_q) begin
                    state_d      = S_REQ;
                    begin_send_d = 1'b1;
                    err_d        = ERR_SEND;
                end
            end
            S_REQ: begin
                // Drop the request as soon as the sender reports it is
                // sending so it falls back to idle instead of re-arming.
                if (send_status == SS_SENDING) begin
                    state_d      = S_WAIT_DONE;
                    begin_send_d = 1'b0;
                end
            end
            S_WAIT_DONE: begin
                if (send_status == SS_IDLE) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = ERR_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            data_length_q <= '0;
            words_q       <= '0;
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
            err_q         <= ERR_IDLE;
            begin_send_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_length_q <= data_length_d;
            words_q       <= words_d;
            rd_cnt_q      <= rd_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            err_q         <= err_d;
            begin_send_q  <= begin_send_d;
            done_q        <= done_d;
        end
    end

    // Write path: FIFO data arriving one cycle after a read is written to RAM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q    <= 1'b0;
            ram_wren_q  <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
        end else begin
            rd_vld_q   <= rd_req;
            ram_wren_q <= rd_vld_q;
            if (rd_vld_q) begin
                ram_wdata_q <= fifo_q;
                ram_waddr_q <= wr_cnt_q[ADDR_W-1:0];
            end
        end
    end

    assign fifo_rden   = rd_req;
    assign ram_wren    = ram_wren_q;
    assign ram_waddr   = ram_waddr_q;
    assign ram_wdata   = ram_wdata_q;
    assign begin_send  = begin_send_q;
    assign data_length = data_length_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_source_recv_ctrl.sv
// Directed bench for source_recv_ctrl: a table of packets (good and bad
// lengths, stalls, early status, busy start) plus a reset-mid-fill sequence.
module tb_source_recv_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] pkt_length;
    logic        fifo_empty;
    logic        fifo_rden;
    logic [15:0] fifo_q;
    logic        ram_wren;
    logic [9:0]  ram_waddr;
    logic [15:0] ram_wdata;
    logic        begin_send;
    logic [31:0] data_length;
    logic [3:0]  send_status;
    logic        done;
    logic [3:0]  err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Receive FIFO model state (written only by the FIFO process)
    int r_total      = 0;
    int rd_empty_err = 0;

    source_recv_ctrl #(.ADDR_W(10), .MAX_BYTES(2048)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pkt_length (pkt_length),
        .fifo_empty (fifo_empty),
        .fifo_rden  (fifo_rden),
        .fifo_q     (fifo_q),
        .ram_wren   (ram_wren),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .begin_send (begin_send),
        .data_length(data_length),
        .send_status(send_status),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data word produced by the n-th FIFO read overall
    function automatic logic [15:0] fdat(input int n);
        logic [31:0] t;
        t = n * 7;
        return t[15:0] ^ 16'hC3A5;
    endfunction

    // Non-show-ahead FIFO: data for a read appears the cycle after fifo_rden
    always @(posedge clk) begin
        if (fifo_rden) begin
            fifo_q  <= fdat(r_total);
            r_total <= r_total + 1;
            if (fifo_empty) rd_empty_err <= rd_empty_err + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic [31:0] len;
        bit          bad;
        bit          stall;
        bit          early;
        int          busy_at;
        int          exp_words;
    } vec_t;

    vec_t vecs[8];

    // Runs one packet; entered and left at a negedge with the DUT in IDLE
    // (or ERR, which becomes IDLE on the following edge).
    task automatic run_vec(input vec_t v, input int idx);
        int base_r, base_e, nw, last_w, cyc, done_cnt;
        bit risen;
        base_r = r_total;
        base_e = rd_empty_err;
        nw     = 0;
        last_w = -100;
        risen  = 0;
        send_status = v.early ? 4'd2 : 4'd0;
        fifo_empty  = 1'b0;
        start       = 1'b1;
        pkt_length  = v.len;
        @(negedge clk);
        start = 1'b0;
        check("err_after_start", 32'(err), v.bad ? 32'd3 : 32'd1);
        check("data_length_latched", data_length, v.len);
        if (v.bad) begin
            check("bad_no_wren", 32'(ram_wren), 32'd0);
            @(negedge clk);
            check("bad_err_held", 32'(err), 32'd3);
            check("bad_no_wren2", 32'(ram_wren), 32'd0);
            check("bad_no_reads", 32'(r_total - base_r), 32'd0);
            $display("vec %0d len=%0d rejected err=%0d", idx, v.len, err);
            return;
        end

        for (cyc = 0; cyc < 3000; cyc++) begin
            if (ram_wren) begin
                check("wr_addr", 32'(ram_waddr), 32'(nw[9:0]));
                check("wr_data", 32'(ram_wdata), 32'(fdat(base_r + nw)));
                nw++;
                last_w = cyc;
            end
            if (begin_send) begin
                risen = 1;
                break;
            end
            fifo_empty = v.stall ? (((cyc / 3) % 2) == 1) : 1'b0;
            start      = (v.busy_at != 0) && (cyc == v.busy_at);
            if (start) pkt_length = 32'd100;
            @(negedge clk);
        end
        start      = 1'b0;
        fifo_empty = 1'b0;
        if (!risen) begin
            check("begin_send_timeout", 32'd0, 32'd1);
            return;
        end
        check("begin_send_after_last_wr", 32'(cyc), 32'(last_w + 1));
        check("num_writes", 32'(nw), 32'(v.exp_words));
        check("num_reads", 32'(r_total - base_r), 32'(v.exp_words));
        check("no_read_while_empty", 32'(rd_empty_err - base_e), 32'd0);
        check("data_length_stable", data_length, v.len);
        check("err_handoff", 32'(err), 32'd2);

        if (v.early) begin
            @(negedge clk);
            check("early_begin_send_one_cycle", 32'(begin_send), 32'd0);
        end else begin
            send_status = 4'd1;
            repeat (3) @(negedge clk);
            check("begin_send_held_while_waiting", 32'(begin_send), 32'd1);
            send_status = 4'd2;
            @(negedge clk);
            check("begin_send_drop_on_sending", 32'(begin_send), 32'd0);
        end
        done_cnt = 0;
        repeat (9) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("no_done_while_sending", 32'(done_cnt), 32'd0);
        check("begin_send_stays_low", 32'(begin_send), 32'd0);
        send_status = 4'd0;
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("err_back_idle", 32'(err), 32'd0);
        @(negedge clk);
        check("done_single_cycle", 32'(done), 32'd0);
        $display("vec %0d len=%0d writes=%0d reads=%0d done", idx, v.len, nw, r_total - base_r);
    endtask

    initial begin
        vecs[0] = '{len: 32'd0,    bad: 1, stall: 0, early: 0, busy_at: 0, exp_words: 0};
        vecs[1] = '{len: 32'd7,    bad: 1, stall: 0, early: 0, busy_at: 0, exp_words: 0};
        vecs[2] = '{len: 32'd2050, bad: 1, stall: 0, early: 0, busy_at: 0, exp_words: 0};
        vecs[3] = '{len: 32'd8,    bad: 0, stall: 1, early: 0, busy_at: 0, exp_words: 4};
        vecs[4] = '{len: 32'd2,    bad: 0, stall: 0, early: 1, busy_at: 0, exp_words: 1};
        vecs[5] = '{len: 32'd64,   bad: 0, stall: 0, early: 0, busy_at: 5, exp_words: 32};
        vecs[6] = '{len: 32'd2048, bad: 0, stall: 0, early: 0, busy_at: 0, exp_words: 1024};
        vecs[7] = '{len: 32'd4,    bad: 0, stall: 0, early: 0, busy_at: 0, exp_words: 2};

        rst         = 1'b1;
        start       = 1'b0;
        pkt_length  = 32'd0;
        fifo_empty  = 1'b1;
        send_status = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_ram_wren", 32'(ram_wren), 32'd0);
        check("rst_fifo_rden", 32'(fifo_rden), 32'd0);
        check("rst_begin_send", 32'(begin_send), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data_length", data_length, 32'd0);
        check("rst_ram_waddr", 32'(ram_waddr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of a full-size fill
        start      = 1'b1;
        pkt_length = 32'd2048;
        fifo_empty = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("midfill_err_filling", 32'(err), 32'd1);
        check("midfill_writing", 32'(ram_wren), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ram_wren", 32'(ram_wren), 32'd0);
        check("async_rst_fifo_rden", 32'(fifo_rden), 32'd0);
        check("async_rst_err", 32'(err), 32'd0);
        check("async_rst_data_length", data_length, 32'd0);
        check("async_rst_ram_waddr", 32'(ram_waddr), 32'd0);
        check("async_rst_begin_send", 32'(begin_send), 32'd0);
        $display("reset mid-fill applied");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(vecs[7], 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
